// File: rtl/leaf_stream_packetizer_if.sv
// User-side HLS ap_vld/ap_ack output stream feeding the leaf packetizer.
interface leaf_stream_packetizer_if #(
  parameter int unsigned PAYLOAD_BITS = 32
) ();
  logic [PAYLOAD_BITS-1:0] din_leaf_user2interface;
  logic                    vld_user2interface;
  logic                    ack_interface2user;

  modport master (
    output din_leaf_user2interface,
    output vld_user2interface,
    input  ack_interface2user
  );

  modport slave (
    input  din_leaf_user2interface,
    input  vld_user2interface,
    output ack_interface2user
  );
endinterface

// File: rtl/leaf_stream_packetizer.sv
// Transmit-side leaf packetizer: wraps user words into BFT packets with address
// sequencing, credit flow control against destination freespace, and resend replay.
module leaf_stream_packetizer #(
  parameter int unsigned PACKET_BITS           = 49,
  parameter int unsigned PAYLOAD_BITS          = 32,
  parameter int unsigned NUM_LEAF_BITS         = 4,
  parameter int unsigned NUM_PORT_BITS         = 4,
  parameter int unsigned NUM_ADDR_BITS         = 7,
  parameter int unsigned FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_LEAF_BITS-1:0] cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0] cfg_dest_port,
  leaf_stream_packetizer_if.slave  user,
  output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
  input  logic                     resend,
  input  logic                     credit_return,
  output logic [NUM_ADDR_BITS:0]   credits,
  output logic                     credit_err
);

  localparam int unsigned RSVD_BITS   = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS
                                        - NUM_ADDR_BITS - PAYLOAD_BITS;
  localparam int unsigned CRED_BITS   = NUM_ADDR_BITS + 1;
  localparam int unsigned SUM_BITS    = NUM_ADDR_BITS + 2;
  localparam int unsigned MAX_CREDITS = 1 << NUM_ADDR_BITS;

  typedef struct packed {
    logic                     valid;
    logic [NUM_LEAF_BITS-1:0] leaf;
    logic [NUM_PORT_BITS-1:0] port;
    logic [NUM_ADDR_BITS-1:0] addr;
    logic [RSVD_BITS-1:0]     rsvd;
    logic [PAYLOAD_BITS-1:0]  payload;
  } pkt_t;

  typedef enum logic {
    RUN      = 1'b0,
    NOCREDIT = 1'b1
  } state_t;

  state_t                   state;
  pkt_t                     dout_q;
  pkt_t                     last_pkt;
  logic [NUM_ADDR_BITS-1:0] wr_addr;

  logic                     accept_c;
  pkt_t                     new_pkt_c;
  logic [SUM_BITS-1:0]      credit_sum_c;
  logic                     credit_ovf_c;
  logic [CRED_BITS-1:0]     credits_next_c;

  // Handshake: a word is consumed only in RUN, with credit, and when no replay is requested.
  assign accept_c = user.vld_user2interface & (credits != '0) & ~resend & ~reset
                    & (state == RUN);
  assign user.ack_interface2user = accept_c;

  always_comb begin
    new_pkt_c         = '0;
    new_pkt_c.valid   = 1'b1;
    new_pkt_c.leaf    = cfg_dest_leaf;
    new_pkt_c.port    = cfg_dest_port;
    new_pkt_c.addr    = wr_addr;
    new_pkt_c.payload = user.din_leaf_user2interface;
  end

  // Credit arithmetic carries an extra bit so a return on a full pool is visible as overflow.
  always_comb begin
    credit_sum_c = SUM_BITS'(credits);
    if (credit_return) begin
      credit_sum_c = credit_sum_c + SUM_BITS'(FREESPACE_UPDATE_SIZE);
    end
    if (accept_c) begin
      credit_sum_c = credit_sum_c - SUM_BITS'(1);
    end
    credit_ovf_c   = credit_sum_c > SUM_BITS'(MAX_CREDITS);
    credits_next_c = credit_ovf_c ? CRED_BITS'(MAX_CREDITS) : credit_sum_c[CRED_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      dout_q     <= '0;
      last_pkt   <= '0;
      wr_addr    <= '0;
      credits    <= CRED_BITS'(MAX_CREDITS);
      credit_err <= 1'b0;
    end else begin
      credits <= credits_next_c;
      if (credit_ovf_c) begin
        credit_err <= 1'b1;
      end

      // Replay wins over new data; the last-packet register is all-zero until the first send.
      if (resend) begin
        dout_q <= last_pkt;
      end else if (accept_c) begin
        dout_q   <= new_pkt_c;
        last_pkt <= new_pkt_c;
        wr_addr  <= wr_addr + NUM_ADDR_BITS'(1);
      end else begin
        dout_q <= '0;
      end

      case (state)
        RUN: begin
          if (accept_c && (credits_next_c == '0)) begin
            state <= NOCREDIT;
          end
        end
        NOCREDIT: begin
          if (credits != '0) begin
            state <= RUN;
          end
        end
      endcase
    end
  end

  assign dout_leaf_interface2bft = dout_q;

endmodule
